rr_mux_arbiter_2x1: RTL and testbench

- Round-robin arbiter and sequencer that shares one downstream valid/ready channel between two upstream requesters.
- Drives the select of a 2:1 steering mux.
- Grants are packet-locked: the winner keeps the channel until its `last` beat, or until a maximum-burst limit forces release.
- Sits between two packet sources (e.g. two UART/ALU result streams) and a single shared sink.

---
 rtl/arb_pkg.sv | 12 +
 rtl/rr_mux_arbiter_2x1_mux2.sv | 11 +
 rtl/rr_mux_arbiter_2x1.sv | 127 ++++++++++++
 tb/tb_rr_mux_arbiter_2x1.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
package arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rr_mux_arbiter_2x1_mux2.sv
// Single-bit 2:1 steering mux cell; replicated per bit by the arbiter top.
module rr_mux_arbiter_2x1_mux2 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);

  assign y = s ? b : a;

endmodule

// File: rtl/rr_mux_arbiter_2x1.sv
// Packet-locked round-robin arbiter sharing one valid/ready channel between two
// requesters, with an optional per-grant beat limit that forces release.
module rr_mux_arbiter_2x1
  import arb_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              sel,
  output logic              busy
);

  localparam int CNT_W_RAW = $clog2(MAX_BURST + 1);
  localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam int LIMIT_I   = (MAX_BURST == 0) ? 0 : MAX_BURST - 1;
  localparam logic [CNT_W-1:0] LIMIT = LIMIT_I[CNT_W-1:0];
  localparam bit LIMIT_EN  = (MAX_BURST != 0);
  localparam int MUX_W     = DATA_W + 2;

  state_t           state;
  logic             prio;
  logic [CNT_W-1:0] beat_cnt;

  logic [MUX_W-1:0] mux_in0;
  logic [MUX_W-1:0] mux_in1;
  logic [MUX_W-1:0] mux_out;
  logic             mux_valid;
  logic             transfer;
  logic             release_now;

  assign mux_in0 = {req0_valid, req0_last, req0_data};
  assign mux_in1 = {req1_valid, req1_last, req1_data};

  for (genvar i = 0; i < MUX_W; i++) begin : g_mux
    rr_mux_arbiter_2x1_mux2 u_mux (
      .a(mux_in0[i]),
      .b(mux_in1[i]),
      .s(sel),
      .y(mux_out[i])
    );
  end

  assign mux_valid = mux_out[MUX_W-1];
  assign out_last  = mux_out[MUX_W-2];
  assign out_data  = mux_out[DATA_W-1:0];

  // Channel handshake: only the granted requester sees the sink's ready.
  always_comb begin
    out_valid  = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (busy) begin
      out_valid  = mux_valid;
      req0_ready = (sel == REQ0) ? out_ready : 1'b0;
      req1_ready = (sel == REQ1) ? out_ready : 1'b0;
    end else begin
      out_valid  = 1'b0;
    end
  end

  assign transfer    = out_valid & out_ready;
  assign release_now = transfer & (out_last | (LIMIT_EN & (beat_cnt == LIMIT)));

  // Arbiter FSM, priority pointer and burst counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= REQ0;
      prio     <= REQ0;
      busy     <= 1'b0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_valid && req1_valid) begin
            sel   <= prio;
            state <= GRANT;
            busy  <= 1'b1;
          end else if (req0_valid) begin
            sel   <= REQ0;
            state <= GRANT;
            busy  <= 1'b1;
          end else if (req1_valid) begin
            sel   <= REQ1;
            state <= GRANT;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        GRANT: begin
          if (release_now) begin
            state    <= IDLE;
            busy     <= 1'b0;
            beat_cnt <= '0;
            prio     <= ~sel;
          end else if (transfer && LIMIT_EN) begin
            beat_cnt <= beat_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            beat_cnt <= beat_cnt;
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          beat_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter_2x1.sv
// Directed bench for rr_mux_arbiter_2x1 (MAX_BURST=4): cycle vector table plus
// a hand-written asynchronous reset sequence.
module tb_rr_mux_arbiter_2x1;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_last, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] req1_data;
  logic       out_valid, out_last, out_ready;
  logic [7:0] out_data;
  logic       sel, busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rr_mux_arbiter_2x1 #(.DATA_W(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .sel(sel), .busy(busy)
  );

  typedef struct {
    logic       r0v; logic [7:0] r0d; logic r0l;
    logic       r1v; logic [7:0] r1d; logic r1l;
    logic       ordy;
    logic       ev;  logic [7:0] ed;  logic el;
    logic       e0r; logic       e1r; logic es; logic eb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r0v, input logic [7:0] r0d, input logic r0l,
                              input logic r1v, input logic [7:0] r1d, input logic r1l,
                              input logic ordy, input logic ev, input logic [7:0] ed,
                              input logic el, input logic e0r, input logic e1r,
                              input logic es, input logic eb);
    vec_t v;
    v.r0v = r0v; v.r0d = r0d; v.r0l = r0l;
    v.r1v = r1v; v.r1d = r1d; v.r1l = r1l;
    v.ordy = ordy;
    v.ev = ev; v.ed = ed; v.el = el;
    v.e0r = e0r; v.e1r = e1r; v.es = es; v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r0v, input logic [7:0] r0d, input logic r0l,
                       input logic r1v, input logic [7:0] r1d, input logic r1l,
                       input logic ordy);
    req0_valid = r0v; req0_data = r0d; req0_last = r0l;
    req1_valid = r1v; req1_data = r1d; req1_last = r1l;
    out_ready  = ordy;
  endtask

  task automatic chk_ctrl(input string tag, input logic ev, input logic e0r,
                          input logic e1r, input logic es, input logic eb);
    chk({tag, ".out_valid"},  {7'd0, out_valid},  {7'd0, ev});
    chk({tag, ".req0_ready"}, {7'd0, req0_ready}, {7'd0, e0r});
    chk({tag, ".req1_ready"}, {7'd0, req1_ready}, {7'd0, e1r});
    chk({tag, ".sel"},        {7'd0, sel},        {7'd0, es});
    chk({tag, ".busy"},       {7'd0, busy},       {7'd0, eb});
  endtask

  initial begin
    // T1: simultaneous requests, 3-beat packets each
    vecs.push_back(mk(1'b1,8'h11,1'b0, 1'b1,8'h21,1'b0, 1'b1, 1'b0,8'h00,1'b0, 1'b0,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b1,8'h11,1'b0, 1'b1,8'h21,1'b0, 1'b1, 1'b1,8'h11,1'b0, 1'b1,1'b0,1'b0,1'b1));
    vecs.push_back(mk(1'b1,8'h12,1'b0, 1'b1,8'h21,1'b0, 1'b1, 1'b1,8'h12,1'b0, 1'b1,1'b0,1'b0,1'b1));
    vecs.push_back(mk(1'b1,8'h13,1'b1, 1'b1,8'h21,1'b0, 1'b1, 1'b1,8'h13,1'b1, 1'b1,1'b0,1'b0,1'b1));
    vecs.push_back(mk(1'b0,8'h00,1'b0, 1'b1,8'h21,1'b0, 1'b1, 1'b0,8'h00,1'b0, 1'b0,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,8'h00,1'b0, 1'b1,8'h21,1'b0, 1'b1, 1'b1,8'h21,1'b0, 1'b0,1'b1,1'b1,1'b1));
    vecs.push_back(mk(1'b0,8'h00,1'b0, 1'b1,8'h22,1'b0, 1'b1, 1'b1,8'h22,1'b0, 1'b0,1'b1,1'b1,1'b1));
    vecs.push_back(mk(1'b0,8'h00,1'b0, 1'b1,8'h23,1'b1, 1'b1, 1'b1,8'h23,1'b1, 1'b0,1'b1,1'b1,1'b1));
    vecs.push_back(mk(1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b0,8'h00,1'b0, 1'b0,1'b0,1'b1,1'b0));
    // T2: req1 alone, 2 beats
    vecs.push_back(mk(1'b0,8'h00,1'b0, 1'b1,8'h31,1'b0, 1'b1, 1'b0,8'h00,1'b0, 1'b0,1'b0,1'b1,1'b0));
    vecs.push_back(mk(1'b0,8'h00,1'b0, 1'b1,8'h31,1'b0, 1'b1, 1'b1,8'h31,1'b0, 1'b0,1'b1,1'b1,1'b1));
    vecs.push_back(mk(1'b0,8'h00,1'b0, 1'b1,8'h32,1'b1, 1'b1, 1'b1,8'h32,1'b1, 1'b0,1'b1,1'b1,1'b1));
    vecs.push_back(mk(1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b0,8'h00,1'b0, 1'b0,1'b0,1'b1,1'b0));
    // T3: 6-beat req0 packet split by the 4-beat limit, req1 in between
    vecs.push_back(mk(1'b1,8'h41,1'b0, 1'b1,8'h51,1'b0, 1'b1, 1'b0,8'h00,1'b0, 1'b0,1'b0,1'b1,1'b0));
    vecs.push_back(mk(1'b1,8'h41,1'b0, 1'b1,8'h51,1'b0, 1'b1, 1'b1,8'h41,1'b0, 1'b1,1'b0,1'b0,1'b1));
    vecs.push_back(mk(1'b1,8'h42,1'b0, 1'b1,8'h51,1'b0, 1'b1, 1'b1,8'h42,1'b0, 1'b1,1'b0,1'b0,1'b1));
    vecs.push_back(mk(1'b1,8'h43,1'b0, 1'b1,8'h51,1'b0, 1'b1, 1'b1,8'h43,1'b0, 1'b1,1'b0,1'b0,1'b1));
    vecs.push_back(mk(1'b1,8'h44,1'b0, 1'b1,8'h51,1'b0, 1'b1, 1'b1,8'h44,1'b0, 1'b1,1'b0,1'b0,1'b1));
    vecs.push_back(mk(1'b1,8'h45,1'b0, 1'b1,8'h51,1'b0, 1'b1, 1'b0,8'h00,1'b0, 1'b0,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b1,8'h45,1'b0, 1'b1,8'h51,1'b0, 1'b1, 1'b1,8'h51,1'b0, 1'b0,1'b1,1'b1,1'b1));
    vecs.push_back(mk(1'b1,8'h45,1'b0, 1'b1,8'h52,1'b1, 1'b1, 1'b1,8'h52,1'b1, 1'b0,1'b1,1'b1,1'b1));
    vecs.push_back(mk(1'b1,8'h45,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b0,8'h00,1'b0, 1'b0,1'b0,1'b1,1'b0));
    vecs.push_back(mk(1'b1,8'h45,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b1,8'h45,1'b0, 1'b1,1'b0,1'b0,1'b1));
    vecs.push_back(mk(1'b1,8'h46,1'b1, 1'b0,8'h00,1'b0, 1'b1, 1'b1,8'h46,1'b1, 1'b1,1'b0,1'b0,1'b1));
    vecs.push_back(mk(1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b0,8'h00,1'b0, 1'b0,1'b0,1'b0,1'b0));
    // T4: sink stalls 3 cycles on beat 2; a counter that moved would release early
    vecs.push_back(mk(1'b1,8'h61,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b0,8'h00,1'b0, 1'b0,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b1,8'h61,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b1,8'h61,1'b0, 1'b1,1'b0,1'b0,1'b1));
    vecs.push_back(mk(1'b1,8'h62,1'b0, 1'b0,8'h00,1'b0, 1'b0, 1'b1,8'h62,1'b0, 1'b0,1'b0,1'b0,1'b1));
    vecs.push_back(mk(1'b1,8'h62,1'b0, 1'b0,8'h00,1'b0, 1'b0, 1'b1,8'h62,1'b0, 1'b0,1'b0,1'b0,1'b1));
    vecs.push_back(mk(1'b1,8'h62,1'b0, 1'b0,8'h00,1'b0, 1'b0, 1'b1,8'h62,1'b0, 1'b0,1'b0,1'b0,1'b1));
    vecs.push_back(mk(1'b1,8'h62,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b1,8'h62,1'b0, 1'b1,1'b0,1'b0,1'b1));
    vecs.push_back(mk(1'b1,8'h63,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b1,8'h63,1'b0, 1'b1,1'b0,1'b0,1'b1));
    vecs.push_back(mk(1'b1,8'h64,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b1,8'h64,1'b0, 1'b1,1'b0,1'b0,1'b1));
    vecs.push_back(mk(1'b1,8'h65,1'b1, 1'b0,8'h00,1'b0, 1'b1, 1'b0,8'h00,1'b0, 1'b0,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b1,8'h65,1'b1, 1'b0,8'h00,1'b0, 1'b1, 1'b1,8'h65,1'b1, 1'b1,1'b0,1'b0,1'b1));
    vecs.push_back(mk(1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b0,8'h00,1'b0, 1'b0,1'b0,1'b0,1'b0));
    // T6: granted req0 drops valid for 2 cycles while req1 waits
    vecs.push_back(mk(1'b1,8'h71,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b0,8'h00,1'b0, 1'b0,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b1,8'h71,1'b0, 1'b1,8'h81,1'b1, 1'b1, 1'b1,8'h71,1'b0, 1'b1,1'b0,1'b0,1'b1));
    vecs.push_back(mk(1'b0,8'h00,1'b0, 1'b1,8'h81,1'b1, 1'b1, 1'b0,8'h00,1'b0, 1'b1,1'b0,1'b0,1'b1));
    vecs.push_back(mk(1'b0,8'h00,1'b0, 1'b1,8'h81,1'b1, 1'b1, 1'b0,8'h00,1'b0, 1'b1,1'b0,1'b0,1'b1));
    vecs.push_back(mk(1'b1,8'h72,1'b1, 1'b1,8'h81,1'b1, 1'b1, 1'b1,8'h72,1'b1, 1'b1,1'b0,1'b0,1'b1));
    vecs.push_back(mk(1'b0,8'h00,1'b0, 1'b1,8'h81,1'b1, 1'b1, 1'b0,8'h00,1'b0, 1'b0,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,8'h00,1'b0, 1'b1,8'h81,1'b1, 1'b1, 1'b1,8'h81,1'b1, 1'b0,1'b1,1'b1,1'b1));
    vecs.push_back(mk(1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0, 1'b1, 1'b0,8'h00,1'b0, 1'b0,1'b0,1'b1,1'b0));

    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    #1;
    chk_ctrl("in_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_ctrl("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      @(negedge clk);
      drive(vecs[i].r0v, vecs[i].r0d, vecs[i].r0l, vecs[i].r1v, vecs[i].r1d, vecs[i].r1l, vecs[i].ordy);
      #1;
      tag = $sformatf("v%0d", i);
      chk_ctrl(tag, vecs[i].ev, vecs[i].e0r, vecs[i].e1r, vecs[i].es, vecs[i].eb);
      if (vecs[i].ev) begin
        chk({tag, ".out_data"}, out_data, vecs[i].ed);
        chk({tag, ".out_last"}, {7'd0, out_last}, {7'd0, vecs[i].el});
      end
    end

    // T5: one-beat req0 packet leaves prio=1, then reset during beat 2 of the next
    @(negedge clk); drive(1'b1, 8'hA1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk); #1; chk("r5.a1", out_data, 8'hA1);
    @(negedge clk); drive(1'b1, 8'h91, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk); #1; chk("r5.b1", out_data, 8'h91);
    chk_ctrl("r5.b1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk); drive(1'b1, 8'h92, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    #1; chk("r5.b2", out_data, 8'h92);
    #1; rst = 1'b1;
    #1; chk_ctrl("r5.rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 8'hB1, 1'b1, 1'b1, 8'hC1, 1'b1, 1'b1);
    #1; chk_ctrl("r5.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1;
    chk_ctrl("r5.regrant", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("r5.regrant.out_data", out_data, 8'hB1);
    @(negedge clk); drive(1'b0, 8'h00, 1'b0, 1'b1, 8'hC1, 1'b1, 1'b1);
    @(negedge clk); #1;
    chk_ctrl("r5.next", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("r5.next.out_data", out_data, 8'hC1);
    @(negedge clk); drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
